// File: rtl/nco_slew.sv
// DPLL numerically controlled oscillator with rate-limited frequency slewing,
// clamped phase adjustment, hard phase resync and a bit-cell counter.
module nco_slew #(
  parameter int unsigned      ACC_W      = 32,
  parameter int unsigned      ADJ_W      = 16,
  parameter int unsigned      ADJ_LIMIT  = 1024,
  parameter logic [ACC_W-1:0] FW_INIT    = 32'h00A3D70A,
  parameter logic [ACC_W-1:0] SLEW_STEP  = 4096,
  parameter int unsigned      SLEW_DIV   = 16,
  parameter logic [ACC_W-1:0] SYNC_PHASE = '0,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] fw_in,
  input  logic             fw_load,
  output logic             fw_ready,
  input  logic [ADJ_W-1:0] phase_adj,
  input  logic             phase_adj_valid,
  input  logic             phase_sync,
  output logic             bit_clk,
  output logic             bit_tick,
  output logic             sample_point,
  output logic [ACC_W-1:0] phase_accum,
  output logic [ACC_W-1:0] freq_cur,
  output logic             slewing,
  output logic             adj_clamped,
  output logic [CNT_W-1:0] cell_count
);

  localparam int unsigned DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);
  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic signed [ADJ_W-1:0] LIM_P = ADJ_W'(ADJ_LIMIT);
  localparam logic signed [ADJ_W-1:0] LIM_N = -LIM_P;

  typedef enum logic [1:0] {IDLE, SLEW_UP, SLEW_DOWN, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] target_q, target_d;
  logic [ACC_W-1:0] freq_q, freq_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             samp_q, samp_d;
  logic             clamp_q, clamp_d;
  logic             bclk_q, bclk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0]        gap_up, gap_dn;
  logic signed [ADJ_W-1:0] adj_eff;
  logic                    clamp_hit;
  logic [SUM_W-1:0]        sum;

  // State register and slew datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      freq_q   <= FW_INIT;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      freq_q   <= freq_d;
      div_q    <= div_d;
    end
  end

  assign gap_up = target_q - freq_q;
  assign gap_dn = freq_q - target_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    freq_d   = freq_q;
    div_d    = div_q;
    unique case (state_q)
      IDLE: begin
        if (fw_load) begin
          target_d = fw_in;
          div_d    = '0;
          if (SLEW_STEP == '0) begin
            freq_d  = fw_in;
            state_d = DONE;
          end else if (fw_in == freq_q) begin
            state_d = DONE;
          end else if (fw_in > freq_q) begin
            state_d = SLEW_UP;
          end else begin
            state_d = SLEW_DOWN;
          end
        end
      end
      SLEW_UP: begin
        if (enable) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            // Compare on the remaining gap so the step never overflows past target
            if (gap_up <= SLEW_STEP) begin
              freq_d  = target_q;
              state_d = DONE;
            end else begin
              freq_d = freq_q + SLEW_STEP;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      SLEW_DOWN: begin
        if (enable) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (gap_dn <= SLEW_STEP) begin
              freq_d  = target_q;
              state_d = DONE;
            end else begin
              freq_d = freq_q - SLEW_STEP;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fw_ready = (state_q == IDLE);
    slewing  = (state_q == SLEW_UP) || (state_q == SLEW_DOWN);
  end

  always_comb begin
    adj_eff   = '0;
    clamp_hit = 1'b0;
    if (phase_adj_valid) begin
      if ($signed(phase_adj) > LIM_P) begin
        adj_eff   = LIM_P;
        clamp_hit = 1'b1;
      end else if ($signed(phase_adj) < LIM_N) begin
        adj_eff   = LIM_N;
        clamp_hit = 1'b1;
      end else begin
        adj_eff = $signed(phase_adj);
      end
    end
  end

  // Two guard bits: 01 marks a forward wrap, 1x a backward wrap below zero
  assign sum = {2'b00, phase_q} + {2'b00, freq_q}
             + {{(SUM_W-ADJ_W){adj_eff[ADJ_W-1]}}, adj_eff};

  always_comb begin
    phase_d = phase_q;
    tick_d  = 1'b0;
    samp_d  = 1'b0;
    clamp_d = 1'b0;
    if (enable) begin
      if (phase_sync) begin
        phase_d = SYNC_PHASE;
      end else begin
        phase_d = sum[ACC_W-1:0];
        tick_d  = (sum[SUM_W-1:ACC_W] == 2'b01);
        samp_d  = (sum[SUM_W-1:ACC_W] == 2'b00) && !phase_q[ACC_W-1] && sum[ACC_W-1];
        clamp_d = clamp_hit;
      end
    end
    bclk_d = bclk_q ^ tick_d;
    cnt_d  = cnt_q + CNT_W'(tick_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      tick_q  <= 1'b0;
      samp_q  <= 1'b0;
      clamp_q <= 1'b0;
      bclk_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      tick_q  <= tick_d;
      samp_q  <= samp_d;
      clamp_q <= clamp_d;
      bclk_q  <= bclk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_accum  = phase_q;
  assign freq_cur     = freq_q;
  assign bit_tick     = tick_q;
  assign sample_point = samp_q;
  assign adj_clamped  = clamp_q;
  assign bit_clk      = bclk_q;
  assign cell_count   = cnt_q;

endmodule
